zigzag_rle: RTL and testbench

- Sits directly downstream of the 12sx8u quantizing multiplier and consumes its 9-bit signed quantized coefficient stream (dctq).
- Buffers each 64-coefficient 8x8 block, arriving in row-major order, in a ping-pong pair of banks.
- Reads each block back in JPEG zigzag order and emits (run, level) symbols with a valid/ready handshake to the downstream entropy coder.
- Symbol types: DC, AC, ZRL and EOB.

---
 rtl/zigzag_rle.sv | 239 +++++++++++++++++++++++
 tb/tb_zigzag_rle.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zigzag_rle.sv
// zigzag_rle: ping-pong buffer for 8x8 quantized coefficient blocks.
// Blocks are written in row-major order, read back in JPEG zigzag order and
// emitted as (run, level) symbols: one DC, AC / ZRL symbols, then EOB.
module zigzag_rle #(
  parameter int DATA_W = 9,
  parameter int RUN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [RUN_W-1:0]  out_run,
  output logic [DATA_W-1:0] out_level,
  output logic              out_dc,
  output logic              out_eob,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow
);

  localparam int                ZCNT_W    = 6;
  localparam int                ZRL_LEN_I = 1 << RUN_W;
  localparam logic [ZCNT_W-1:0] ZRL_LEN   = ZCNT_W'(ZRL_LEN_I);
  localparam logic [ZCNT_W-1:0] ZRL_TWICE = ZCNT_W'(2 * ZRL_LEN_I);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DC   = 3'd1,
    ST_SCAN = 3'd2,
    ST_ZRL  = 3'd3,
    ST_EOB  = 3'd4
  } state_t;

  // Zigzag position -> row-major index within the 8x8 block.
  function automatic logic [5:0] zz(input logic [5:0] k);
    logic [5:0] idx;
    case (k)
      6'd0:  idx = 6'd0;  6'd1:  idx = 6'd1;  6'd2:  idx = 6'd8;  6'd3:  idx = 6'd16;
      6'd4:  idx = 6'd9;  6'd5:  idx = 6'd2;  6'd6:  idx = 6'd3;  6'd7:  idx = 6'd10;
      6'd8:  idx = 6'd17; 6'd9:  idx = 6'd24; 6'd10: idx = 6'd32; 6'd11: idx = 6'd25;
      6'd12: idx = 6'd18; 6'd13: idx = 6'd11; 6'd14: idx = 6'd4;  6'd15: idx = 6'd5;
      6'd16: idx = 6'd12; 6'd17: idx = 6'd19; 6'd18: idx = 6'd26; 6'd19: idx = 6'd33;
      6'd20: idx = 6'd40; 6'd21: idx = 6'd48; 6'd22: idx = 6'd41; 6'd23: idx = 6'd34;
      6'd24: idx = 6'd27; 6'd25: idx = 6'd20; 6'd26: idx = 6'd13; 6'd27: idx = 6'd6;
      6'd28: idx = 6'd7;  6'd29: idx = 6'd14; 6'd30: idx = 6'd21; 6'd31: idx = 6'd28;
      6'd32: idx = 6'd35; 6'd33: idx = 6'd42; 6'd34: idx = 6'd49; 6'd35: idx = 6'd56;
      6'd36: idx = 6'd57; 6'd37: idx = 6'd50; 6'd38: idx = 6'd43; 6'd39: idx = 6'd36;
      6'd40: idx = 6'd29; 6'd41: idx = 6'd22; 6'd42: idx = 6'd15; 6'd43: idx = 6'd23;
      6'd44: idx = 6'd30; 6'd45: idx = 6'd37; 6'd46: idx = 6'd44; 6'd47: idx = 6'd51;
      6'd48: idx = 6'd58; 6'd49: idx = 6'd59; 6'd50: idx = 6'd52; 6'd51: idx = 6'd45;
      6'd52: idx = 6'd38; 6'd53: idx = 6'd31; 6'd54: idx = 6'd39; 6'd55: idx = 6'd46;
      6'd56: idx = 6'd53; 6'd57: idx = 6'd60; 6'd58: idx = 6'd61; 6'd59: idx = 6'd54;
      6'd60: idx = 6'd47; 6'd61: idx = 6'd55; 6'd62: idx = 6'd62; 6'd63: idx = 6'd63;
      default: idx = 6'd0;
    endcase
    return idx;
  endfunction

  // Storage and write-side bookkeeping
  logic [DATA_W-1:0] mem_r [0:127];
  logic              wr_bank_r;
  logic [5:0]        wr_addr_r;
  logic              rd_bank_r;
  logic [1:0]        full_r;
  logic              in_ready_r;
  logic              overflow_r;

  // Read FSM and output symbol register
  state_t            state_r;
  state_t            state_nx_s;
  logic [5:0]        k_r;
  logic [5:0]        k_nx_s;
  logic [ZCNT_W-1:0] zcnt_r;
  logic [ZCNT_W-1:0] zcnt_nx_s;
  logic              out_valid_r;
  logic [RUN_W-1:0]  out_run_r;
  logic [DATA_W-1:0] out_level_r;
  logic              out_dc_r;
  logic              out_eob_r;

  logic              emit_s;
  logic [RUN_W-1:0]  emit_run_s;
  logic [DATA_W-1:0] emit_level_s;
  logic              emit_dc_s;
  logic              emit_eob_s;

  logic              wr_en_s;
  logic              wr_done_s;
  logic              eob_acc_s;
  logic              advance_s;
  logic [1:0]        full_set_s;
  logic [1:0]        full_clr_s;
  logic [1:0]        full_nx_s;
  logic              wr_bank_nx_s;
  logic              rd_bank_nx_s;
  logic [DATA_W-1:0] dc_coef_s;
  logic [DATA_W-1:0] scan_coef_s;

  assign wr_en_s   = in_valid && in_ready_r;
  assign wr_done_s = wr_en_s && (wr_addr_r == 6'd63);
  assign eob_acc_s = out_valid_r && out_ready && out_eob_r;
  // The output register is free when empty or being taken this cycle.
  assign advance_s = !out_valid_r || out_ready;

  // A completing write and an EOB acceptance always refer to different banks.
  assign full_set_s   = wr_done_s ? (2'b01 << wr_bank_r) : 2'b00;
  assign full_clr_s   = eob_acc_s ? (2'b01 << rd_bank_r) : 2'b00;
  assign full_nx_s    = (full_r | full_set_s) & ~full_clr_s;
  assign wr_bank_nx_s = wr_done_s ? ~wr_bank_r : wr_bank_r;
  assign rd_bank_nx_s = eob_acc_s ? ~rd_bank_r : rd_bank_r;

  // Buffer reads are combinational so a symbol can be produced every cycle.
  assign dc_coef_s   = mem_r[{rd_bank_r, 6'd0}];
  assign scan_coef_s = mem_r[{rd_bank_r, zz(k_r)}];

  // Coefficient storage, addressed {bank, row-major index}; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[{wr_bank_r, wr_addr_r}] <= in_data;
    end
  end

  // Write pointer, bank ownership flags, registered in_ready and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_r  <= 1'b0;
      wr_addr_r  <= 6'd0;
      rd_bank_r  <= 1'b0;
      full_r     <= 2'b00;
      in_ready_r <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      wr_addr_r  <= wr_en_s ? (wr_addr_r + 6'd1) : wr_addr_r;
      wr_bank_r  <= wr_bank_nx_s;
      rd_bank_r  <= rd_bank_nx_s;
      full_r     <= full_nx_s;
      in_ready_r <= ~full_nx_s[wr_bank_nx_s];
      overflow_r <= overflow_r | (in_valid & ~in_ready_r);
    end
  end

  // Next-state and symbol selection for the zigzag scan.
  always_comb begin
    state_nx_s   = state_r;
    k_nx_s       = k_r;
    zcnt_nx_s    = zcnt_r;
    emit_s       = 1'b0;
    emit_run_s   = {RUN_W{1'b0}};
    emit_level_s = {DATA_W{1'b0}};
    emit_dc_s    = 1'b0;
    emit_eob_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Waiting for an empty output register keeps a pending EOB from
        // restarting the bank it is about to release.
        if (!out_valid_r && full_r[rd_bank_r]) begin
          k_nx_s     = 6'd1;
          zcnt_nx_s  = {ZCNT_W{1'b0}};
          state_nx_s = ST_DC;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_DC: begin
        emit_s       = 1'b1;
        emit_level_s = dc_coef_s;
        emit_dc_s    = 1'b1;
        state_nx_s   = ST_SCAN;
      end
      ST_SCAN: begin
        if (scan_coef_s == {DATA_W{1'b0}}) begin
          zcnt_nx_s  = zcnt_r + {{(ZCNT_W-1){1'b0}}, 1'b1};
          k_nx_s     = k_r + 6'd1;
          state_nx_s = (k_r == 6'd63) ? ST_EOB : ST_SCAN;
        end else if (zcnt_r >= ZRL_LEN) begin
          emit_s     = 1'b1;
          emit_run_s = {RUN_W{1'b1}};
          zcnt_nx_s  = zcnt_r - ZRL_LEN;
          state_nx_s = (zcnt_r >= ZRL_TWICE) ? ST_ZRL : ST_SCAN;
        end else begin
          emit_s       = 1'b1;
          emit_run_s   = zcnt_r[RUN_W-1:0];
          emit_level_s = scan_coef_s;
          zcnt_nx_s    = {ZCNT_W{1'b0}};
          k_nx_s       = k_r + 6'd1;
          state_nx_s   = (k_r == 6'd63) ? ST_EOB : ST_SCAN;
        end
      end
      ST_ZRL: begin
        // Further ZRLs owed before the nonzero coefficient at k.
        emit_s     = 1'b1;
        emit_run_s = {RUN_W{1'b1}};
        zcnt_nx_s  = zcnt_r - ZRL_LEN;
        state_nx_s = (zcnt_r >= ZRL_TWICE) ? ST_ZRL : ST_SCAN;
      end
      ST_EOB: begin
        emit_s     = 1'b1;
        emit_eob_s = 1'b1;
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, scan counters and the output symbol register; all hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      k_r         <= 6'd0;
      zcnt_r      <= {ZCNT_W{1'b0}};
      out_valid_r <= 1'b0;
      out_run_r   <= {RUN_W{1'b0}};
      out_level_r <= {DATA_W{1'b0}};
      out_dc_r    <= 1'b0;
      out_eob_r   <= 1'b0;
    end else if (advance_s) begin
      state_r     <= state_nx_s;
      k_r         <= k_nx_s;
      zcnt_r      <= zcnt_nx_s;
      out_valid_r <= emit_s;
      out_run_r   <= emit_run_s;
      out_level_r <= emit_level_s;
      out_dc_r    <= emit_dc_s;
      out_eob_r   <= emit_eob_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign overflow  = overflow_r;
  assign out_valid = out_valid_r;
  assign out_run   = out_run_r;
  assign out_level = out_level_r;
  assign out_dc    = out_dc_r;
  assign out_eob   = out_eob_r;

endmodule

// File: tb/tb_zigzag_rle.sv
// tb_zigzag_rle: directed and randomized blocks checked against a run-length
// model that walks the zigzag diagonals arithmetically.
module tb_zigzag_rle;

  typedef struct packed {
    logic [3:0] run;
    logic [8:0] level;
    logic       dc;
    logic       eob;
  } sym_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_run;
  logic [8:0] out_level;
  logic       out_dc;
  logic       out_eob;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;

  logic ready_q;
  logic rand_ready;
  logic rnd_rdy;

  int   n_cmp = 0;
  int   n_err = 0;
  logic [8:0] blk [8][64];
  int   zz [64];
  sym_t exp_q [$];
  sym_t got_q [$];
  logic hold_pend;
  sym_t held_sym;
  sym_t cur_sym;

  assign out_ready = rand_ready ? rnd_rdy : ready_q;

  always #5 clk = ~clk;

  zigzag_rle #(.DATA_W(9), .RUN_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_run   (out_run),
    .out_level (out_level),
    .out_dc    (out_dc),
    .out_eob   (out_eob),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic sym_t mk(input logic [3:0] r, input logic [8:0] l, input logic d, input logic e);
    sym_t s;
    s.run = r; s.level = l; s.dc = d; s.eob = e;
    return s;
  endfunction

  // Zigzag order: walk anti-diagonals, upwards on even ones, downwards on odd ones.
  task automatic build_zz();
    int n;
    n = 0;
    for (int s = 0; s < 15; s++) begin
      for (int j = 0; j < 8; j++) begin
        int row;
        int col;
        row = (s % 2 == 1) ? j : (7 - j);
        col = s - row;
        if (col >= 0 && col < 8) begin
          zz[n] = row * 8 + col;
          n++;
        end
      end
    end
  endtask

  // JPEG-style run-length coding of one block into the expected queue.
  task automatic model_block(input int s);
    int last;
    int run;
    logic [8:0] v;
    exp_q.push_back(mk(4'd0, blk[s][zz[0]], 1'b1, 1'b0));
    last = 0;
    for (int k = 1; k < 64; k++) if (blk[s][zz[k]] != 9'd0) last = k;
    run = 0;
    for (int k = 1; k <= last; k++) begin
      v = blk[s][zz[k]];
      if (v == 9'd0) run++;
      else begin
        while (run >= 16) begin
          exp_q.push_back(mk(4'd15, 9'd0, 1'b0, 1'b0));
          run -= 16;
        end
        exp_q.push_back(mk(4'(run), v, 1'b0, 1'b0));
        run = 0;
      end
    end
    exp_q.push_back(mk(4'd0, 9'd0, 1'b0, 1'b1));
  endtask

  task automatic fill_blk(input int s, input logic [8:0] v);
    for (int i = 0; i < 64; i++) blk[s][i] = v;
  endtask

  task automatic rand_block(input int s, input int density);
    for (int i = 0; i < 64; i++) begin
      if (int'($urandom_range(0, 99)) < density) blk[s][i] = 9'($urandom_range(1, 511));
      else blk[s][i] = 9'd0;
    end
  endtask

  // Offer a sample only while in_ready is high, so nothing is ever dropped here.
  task automatic send_block(input int s);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < 64 && guard < 4000) begin
      if (in_ready) begin
        in_valid = 1'b1;
        in_data  = blk[s][i];
        i++;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    check("send_done", i, 64);
  endtask

  task automatic drain(input int exp_n);
    int guard;
    guard = 0;
    while (got_q.size() < exp_q.size() && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (8) @(posedge clk);
    #1;
    check("sym_count", got_q.size(), exp_q.size());
    if (exp_n >= 0) check("sym_count_fixed", got_q.size(), exp_n);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("sym%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Random downstream readiness, used when rand_ready is set.
  initial begin
    rnd_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      rnd_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  // Symbol collector plus hold check: a stalled symbol must not change.
  initial begin
    hold_pend = 1'b0;
    held_sym  = '0;
    forever begin
      @(negedge clk);
      cur_sym = mk(out_run, out_level, out_dc, out_eob);
      if (rst) hold_pend = 1'b0;
      else begin
        if (hold_pend) check("hold", {out_valid, 16'(cur_sym)}, {1'b1, 16'(held_sym)});
        if (out_valid && out_ready) got_q.push_back(cur_sym);
        hold_pend = out_valid && !out_ready;
        held_sym  = cur_sym;
      end
    end
  end

  initial begin
    build_zz();
    rst = 1'b1; in_valid = 1'b0; in_data = 9'd0; ready_q = 1'b0; rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_fields", {out_run, out_level, out_dc, out_eob}, 0);
    check("rst_overflow", overflow, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    ready_q = 1'b1;

    // DC only
    fill_blk(0, 9'd0); blk[0][0] = 9'd5;
    model_block(0); send_block(0); drain(2);
    // two early AC terms, negative and positive
    fill_blk(0, 9'd0); blk[0][1] = 9'h1FD; blk[0][8] = 9'd2;
    model_block(0); send_block(0); drain(4);
    // long run: two ZRLs then (7, 1), nothing trailing
    fill_blk(0, 9'd0); blk[0][29] = 9'd1;
    model_block(0); send_block(0); drain(5);
    // all ones, coefficient 63 nonzero still ends with EOB
    fill_blk(0, 9'd1);
    model_block(0); send_block(0); drain(65);
    // dense random block
    rand_block(0, 50);
    model_block(0); send_block(0); drain(-1);

    // Back-to-back blocks with the output stalled
    ready_q = 1'b0;
    rand_block(0, 40); rand_block(1, 25); rand_block(2, 30);
    model_block(0); model_block(1);
    send_block(0);
    check("bp_in_ready_after64", in_ready, 1);
    send_block(1);
    check("bp_in_ready_after128", in_ready, 0);
    check("bp_overflow_before", overflow, 0);
    in_valid = 1'b1; in_data = blk[2][0];
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_overflow_set", overflow, 1);
    repeat (130) @(posedge clk);
    #1;
    check("bp_in_ready_held", in_ready, 0);
    check("bp_dc_held", {out_valid, out_dc, out_level}, {1'b1, 1'b1, blk[0][0]});
    ready_q = 1'b1;
    model_block(2);
    send_block(2);
    drain(-1);
    check("bp_overflow_sticky", overflow, 1);

    // Reset while a symbol is stalled mid-scan
    fill_blk(3, 9'd1);
    send_block(3);
    repeat (10) @(posedge clk);
    #1;
    ready_q = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_scan_valid", out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_overflow", overflow, 0);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    ready_q = 1'b1;
    rand_block(3, 30);
    model_block(3); send_block(3); drain(-1);

    // Random blocks with random downstream readiness
    rand_ready = 1'b1;
    rand_block(4, 10); rand_block(5, 30); rand_block(6, 60); rand_block(7, 5);
    for (int b = 4; b < 8; b++) model_block(b);
    for (int b = 4; b < 8; b++) send_block(b);
    drain(-1);
    rand_ready = 1'b0;
    check("rand_overflow", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
